// File: rtl/bcd_mem_writer.sv
// ---------------------------------------------------------------------------
// bcd_mem_writer
//
// Copies a snapshot of the seven BCD time/date fields into a downstream
// register file, one field per cycle, whenever the time counter asks for a
// refresh. A concurrent I2C read has priority over the write, so the current
// write is retried until the bus is free.
//
// Parameters:
//   BASE_ADDR    register-file address of the seconds field; the seven fields
//                occupy BASE_ADDR..BASE_ADDR+6, wrapping modulo 16.
//
// Optional build macro:
//   BCD_CHECK_EN when defined, every captured field is checked; a field with
//                any nibble above 9 is written as 8'h00 and bcd_err is set.
//                When undefined, fields pass unchanged and bcd_err is 0.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   update_pulse  one-cycle refresh request from the time counter
//   sec_bcd .. year_bcd  BCD fields (sec, min, hour, day, date, month, year)
//   i2c_read_en   downstream read in progress; the write is not accepted
//   addr          register address of the current write
//   data_out      data of the current write
//   write_en      write request to the register mux
//   busy          refresh sequence in progress
//   done          one-cycle pulse after the last field is accepted
//   overrun       sticky: refresh requested while busy
//   bcd_err       sticky: invalid BCD field captured (BCD_CHECK_EN only)
// ---------------------------------------------------------------------------
module bcd_mem_writer #(
    parameter logic [3:0] BASE_ADDR = 4'h0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       update_pulse,
    input  logic [7:0] sec_bcd,
    input  logic [7:0] min_bcd,
    input  logic [7:0] hour_bcd,
    input  logic [7:0] day_bcd,
    input  logic [7:0] date_bcd,
    input  logic [7:0] month_bcd,
    input  logic [7:0] year_bcd,
    input  logic       i2c_read_en,
    output logic [3:0] addr,
    output logic [7:0] data_out,
    output logic       write_en,
    output logic       busy,
    output logic       done,
    output logic       overrun,
    output logic       bcd_err
);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t          state, state_nxt;
    logic [2:0]      idx, idx_nxt;
    logic            pending, pending_nxt;
    logic [6:0][7:0] shadow, shadow_nxt;
    logic [6:0][7:0] fields_in;
    logic [6:0][7:0] fields_cap;
    logic [3:0]      addr_nxt;
    logic [7:0]      data_nxt;
    logic            we_nxt, busy_nxt, done_nxt, overrun_nxt;

`ifdef BCD_CHECK_EN
    logic            err_q, err_nxt, cap_err;

    function automatic logic bcd_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction
`endif

    // Field order in the shadow file is also the write order.
    always_comb begin
        fields_in[0] = sec_bcd;
        fields_in[1] = min_bcd;
        fields_in[2] = hour_bcd;
        fields_in[3] = day_bcd;
        fields_in[4] = date_bcd;
        fields_in[5] = month_bcd;
        fields_in[6] = year_bcd;
    end

    always_comb begin
        fields_cap = fields_in;
`ifdef BCD_CHECK_EN
        cap_err = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (!bcd_ok(fields_in[i])) begin
                fields_cap[i] = 8'h00;
                cap_err       = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        pending_nxt = pending;
        shadow_nxt  = shadow;
        addr_nxt    = addr;
        data_nxt    = data_out;
        we_nxt      = write_en;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        overrun_nxt = overrun;
`ifdef BCD_CHECK_EN
        err_nxt     = err_q;
`endif

        case (state)
            IDLE: begin
                we_nxt   = 1'b0;
                busy_nxt = 1'b0;
                if (update_pulse || pending) begin
                    // The first write goes out on the capture edge itself,
                    // so it is fed straight from the captured fields.
                    shadow_nxt  = fields_cap;
                    pending_nxt = 1'b0;
                    idx_nxt     = 3'd0;
                    state_nxt   = WRITE;
                    addr_nxt    = BASE_ADDR;
                    data_nxt    = fields_cap[0];
                    we_nxt      = 1'b1;
                    busy_nxt    = 1'b1;
`ifdef BCD_CHECK_EN
                    err_nxt     = err_q | cap_err;
`endif
                end
            end

            WRITE: begin
                // Requests during a sequence collapse into one pending refresh,
                // including one that lands on the final acceptance edge.
                if (update_pulse) begin
                    pending_nxt = 1'b1;
                    overrun_nxt = 1'b1;
                end
                // A read on the bus discards this write; everything holds and
                // write_en stays high so the same field is retried.
                if (!i2c_read_en) begin
                    if (idx == 3'd6) begin
                        state_nxt = IDLE;
                        we_nxt    = 1'b0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        idx_nxt  = idx + 3'd1;
                        addr_nxt = BASE_ADDR + {1'b0, idx_nxt};
                        data_nxt = shadow[idx_nxt];
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= 3'd0;
            pending  <= 1'b0;
            shadow   <= '0;
            addr     <= 4'h0;
            data_out <= 8'h00;
            write_en <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
`ifdef BCD_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            pending  <= pending_nxt;
            shadow   <= shadow_nxt;
            addr     <= addr_nxt;
            data_out <= data_nxt;
            write_en <= we_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            overrun  <= overrun_nxt;
`ifdef BCD_CHECK_EN
            err_q    <= err_nxt;
`endif
        end
    end

`ifdef BCD_CHECK_EN
    assign bcd_err = err_q;
`else
    assign bcd_err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_mem_writer.sv
// ---------------------------------------------------------------------------
// tb_bcd_mem_writer
//
// Two instances share all inputs: one at BASE_ADDR 0 and one at BASE_ADDR C.
// A transaction-level reference model runs alongside every clock edge, and
// table-driven and hand-written sequences add explicit expected values.
// ---------------------------------------------------------------------------
module tb_bcd_mem_writer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       update_pulse = 1'b0;
    logic       i2c_read_en = 1'b0;
    logic [7:0] sec_bcd = 8'h00, min_bcd = 8'h00, hour_bcd = 8'h00, day_bcd = 8'h01;
    logic [7:0] date_bcd = 8'h01, month_bcd = 8'h01, year_bcd = 8'h00;

    logic [3:0] addr0, addr1;
    logic [7:0] data0, data1;
    logic       we0, we1, busy0, busy1, done0, done1, ovr0, ovr1, err0, err1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_mem_writer #(.BASE_ADDR(4'h0)) dut0 (
        .clk(clk), .rst_n(rst_n), .update_pulse(update_pulse),
        .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hour_bcd(hour_bcd), .day_bcd(day_bcd),
        .date_bcd(date_bcd), .month_bcd(month_bcd), .year_bcd(year_bcd),
        .i2c_read_en(i2c_read_en), .addr(addr0), .data_out(data0), .write_en(we0),
        .busy(busy0), .done(done0), .overrun(ovr0), .bcd_err(err0)
    );

    bcd_mem_writer #(.BASE_ADDR(4'hC)) dut1 (
        .clk(clk), .rst_n(rst_n), .update_pulse(update_pulse),
        .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hour_bcd(hour_bcd), .day_bcd(day_bcd),
        .date_bcd(date_bcd), .month_bcd(month_bcd), .year_bcd(year_bcd),
        .i2c_read_en(i2c_read_en), .addr(addr1), .data_out(data1), .write_en(we1),
        .busy(busy1), .done(done1), .overrun(ovr1), .bcd_err(err1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks which field (0..6) of a frozen snapshot is on offer, plus the
    // refresh request, overrun and error flags.
    logic [7:0] m_snap [7];
    bit         m_active, m_pend, m_ovr, m_err, m_done, m_seen;
    int         m_k;
    logic [7:0] m_data;

    function automatic bit bad_bcd(input logic [7:0] v);
        return (int'(v) / 16 > 9) || (int'(v) % 16 > 9);
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 7; i++) m_snap[i] = 8'h00;
        m_active = 0; m_pend = 0; m_ovr = 0; m_err = 0; m_done = 0; m_seen = 0;
        m_k = 0; m_data = 8'h00;
    endtask

    task automatic model_step();
        logic [7:0] f [7];
        bit         done_now;
        if (!rst_n) begin
            model_reset();
            return;
        end
        done_now = 0;
        f[0] = sec_bcd; f[1] = min_bcd; f[2] = hour_bcd; f[3] = day_bcd;
        f[4] = date_bcd; f[5] = month_bcd; f[6] = year_bcd;
        if (!m_active) begin
            if (update_pulse || m_pend) begin
                for (int i = 0; i < 7; i++) begin
                    m_snap[i] = f[i];
`ifdef BCD_CHECK_EN
                    if (bad_bcd(f[i])) begin
                        m_snap[i] = 8'h00;
                        m_err     = 1;
                    end
`endif
                end
                m_pend = 0; m_active = 1; m_seen = 1; m_k = 0; m_data = m_snap[0];
            end
        end else begin
            if (update_pulse) begin
                m_pend = 1;
                m_ovr  = 1;
            end
            if (!i2c_read_en) begin
                if (m_k == 6) begin
                    m_active = 0;
                    done_now = 1;
                end else begin
                    m_k++;
                    m_data = m_snap[m_k];
                end
            end
        end
        m_done = done_now;
    endtask

    task automatic model_compare();
        logic [3:0] ea0, ea1;
        ea0 = m_seen ? 4'((0 + m_k) % 16) : 4'h0;
        ea1 = m_seen ? 4'((12 + m_k) % 16) : 4'h0;
        chk("m_we0", we0, m_active);     chk("m_we1", we1, m_active);
        chk("m_busy0", busy0, m_active); chk("m_busy1", busy1, m_active);
        chk("m_done0", done0, m_done);   chk("m_done1", done1, m_done);
        chk("m_ovr0", ovr0, m_ovr);      chk("m_ovr1", ovr1, m_ovr);
        chk("m_err0", err0, m_err);      chk("m_err1", err1, m_err);
        chk("m_addr0", addr0, ea0);      chk("m_addr1", addr1, ea1);
        chk("m_data0", data0, m_data);   chk("m_data1", data1, m_data);
    endtask

    // One clock: model follows the edge, outputs are sampled 1 time unit later,
    // and the caller drives the next inputs after return.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        model_compare();
    endtask

    task automatic do_reset();
        update_pulse = 0;
        i2c_read_en  = 0;
        rst_n        = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic set_ref_fields();
        sec_bcd = 8'h45; min_bcd = 8'h30; hour_bcd = 8'h12; day_bcd = 8'h03;
        date_bcd = 8'h28; month_bcd = 8'h02; year_bcd = 8'h24;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         upd;
        bit         rd;
        bit         we;
        bit         busy;
        bit         done;
        logic [3:0] addr;
        logic [7:0] data;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit upd, bit rd, bit we, bit busy, bit done,
                                logic [3:0] a, logic [7:0] d);
        vec_t v;
        v.upd = upd; v.rd = rd; v.we = we; v.busy = busy; v.done = done;
        v.addr = a; v.data = d;
        return v;
    endfunction

    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            update_pulse = tbl[i].upd;
            i2c_read_en  = tbl[i].rd;
            tick();
            chk({tag, "_we"},    we0,   tbl[i].we);
            chk({tag, "_busy"},  busy0, tbl[i].busy);
            chk({tag, "_done"},  done0, tbl[i].done);
            chk({tag, "_addr"},  addr0, tbl[i].addr);
            chk({tag, "_data"},  data0, tbl[i].data);
            chk({tag, "_addrC"}, addr1, 4'(tbl[i].addr + 4'hC));
        end
        update_pulse = 0;
        i2c_read_en  = 0;
    endtask

    initial begin
        model_reset();
        do_reset();
        chk("reset_we", we0, 1'b0);
        chk("reset_addr", addr0, 4'h0);
        chk("reset_data", data0, 8'h00);
        chk("reset_done", done0, 1'b0);

        // Unstalled sequence; the second instance covers the wrapping base C.
        set_ref_fields();
        tbl.delete();
        tbl.push_back(mk(1, 0, 1, 1, 0, 4'h0, 8'h45));
        tbl.push_back(mk(0, 0, 1, 1, 0, 4'h1, 8'h30));
        tbl.push_back(mk(0, 0, 1, 1, 0, 4'h2, 8'h12));
        tbl.push_back(mk(0, 0, 1, 1, 0, 4'h3, 8'h03));
        tbl.push_back(mk(0, 0, 1, 1, 0, 4'h4, 8'h28));
        tbl.push_back(mk(0, 0, 1, 1, 0, 4'h5, 8'h02));
        tbl.push_back(mk(0, 0, 1, 1, 0, 4'h6, 8'h24));
        tbl.push_back(mk(0, 0, 0, 0, 1, 4'h6, 8'h24));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'h6, 8'h24));
        run_table("seq");

        // Read collision for two cycles while addr=2.
        tbl.delete();
        tbl.push_back(mk(1, 0, 1, 1, 0, 4'h0, 8'h45));
        tbl.push_back(mk(0, 0, 1, 1, 0, 4'h1, 8'h30));
        tbl.push_back(mk(0, 0, 1, 1, 0, 4'h2, 8'h12));
        tbl.push_back(mk(0, 1, 1, 1, 0, 4'h2, 8'h12));
        tbl.push_back(mk(0, 1, 1, 1, 0, 4'h2, 8'h12));
        tbl.push_back(mk(0, 0, 1, 1, 0, 4'h3, 8'h03));
        tbl.push_back(mk(0, 0, 1, 1, 0, 4'h4, 8'h28));
        tbl.push_back(mk(0, 0, 1, 1, 0, 4'h5, 8'h02));
        tbl.push_back(mk(0, 0, 1, 1, 0, 4'h6, 8'h24));
        tbl.push_back(mk(0, 0, 0, 0, 1, 4'h6, 8'h24));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'h6, 8'h24));
        run_table("stall");

        // Snapshot coherence and pending refresh after overrun.
        do_reset();
        set_ref_fields();
        update_pulse = 1;
        tick();
        update_pulse = 0;
        chk("snap_first_sec", data0, 8'h45);
        sec_bcd = 8'h46;
        tick(); tick(); tick();
        chk("snap_addr3", addr0, 4'h3);
        update_pulse = 1;
        tick();
        update_pulse = 0;
        chk("ovr_set", ovr0, 1'b1);
        chk("ovr_addr4", addr0, 4'h4);
        tick(); tick();
        chk("ovr_last_data", data0, 8'h24);
        tick();
        chk("ovr_done", done0, 1'b1);
        chk("ovr_idle_we", we0, 1'b0);
        tick();
        chk("pend_start_we", we0, 1'b1);
        chk("pend_start_addr", addr0, 4'h0);
        chk("pend_start_sec", data0, 8'h46);
        chk("pend_done_low", done0, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        chk("pend_done2", done0, 1'b1);
        tick();
        chk("pend_no_third", we0, 1'b0);

        // Asynchronous reset in the middle of a sequence.
        do_reset();
        set_ref_fields();
        update_pulse = 1;
        tick();
        update_pulse = 0;
        tick(); tick(); tick(); tick();
        chk("mid_addr4", addr0, 4'h4);
        rst_n = 0;
        #1;
        model_reset();
        chk("arst_we", we0, 1'b0);
        chk("arst_busy", busy0, 1'b0);
        chk("arst_addr", addr0, 4'h0);
        chk("arst_addrC", addr1, 4'h0);
        chk("arst_data", data0, 8'h00);
        model_compare();
        tick();
        chk("arst_no_done", done0, 1'b0);
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_quiet", we0, 1'b0);
            chk("post_rst_done", done0, 1'b0);
        end

        // Invalid BCD in the minutes field.
        do_reset();
        set_ref_fields();
        min_bcd = 8'h5A;
        update_pulse = 1;
        tick();
        update_pulse = 0;
        tick();
        chk("badbcd_addr", addr0, 4'h1);
`ifdef BCD_CHECK_EN
        chk("badbcd_data", data0, 8'h00);
        chk("badbcd_err", err0, 1'b1);
`else
        chk("badbcd_data", data0, 8'h5A);
        chk("badbcd_err", err0, 1'b0);
`endif
        for (int i = 0; i < 7; i++) tick();
        chk("badbcd_idle", we0, 1'b0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if (c % 17 == 0) begin
                sec_bcd   = to_bcd($urandom_range(0, 59));
                min_bcd   = to_bcd($urandom_range(0, 59));
                hour_bcd  = to_bcd($urandom_range(0, 23));
                day_bcd   = to_bcd($urandom_range(1, 7));
                date_bcd  = to_bcd($urandom_range(1, 31));
                month_bcd = to_bcd($urandom_range(1, 12));
                year_bcd  = to_bcd($urandom_range(0, 99));
                if ($urandom_range(0, 5) == 0) hour_bcd = 8'($urandom);
                if ($urandom_range(0, 5) == 0) year_bcd = 8'($urandom);
            end
            update_pulse = ($urandom_range(0, 9) == 0);
            i2c_read_en  = ($urandom_range(0, 3) == 0);
            tick();
        end
        update_pulse = 0;
        i2c_read_en  = 0;
        for (int i = 0; i < 20; i++) tick();
        chk("final_idle", we0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_mem_writer.md
BCD_MEM_WRITER -- requirements
Module: bcd_mem_writer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 4'h0: register-file address of the seconds field; fields occupy BASE_ADDR..BASE_ADDR+6.
REQ-002 SHALL have ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- update_pulse  input  1  one-cycle tick from the time counter requesting a register refresh.
- sec_bcd  input  8  seconds, BCD 00-59.
- min_bcd  input  8  minutes, BCD 00-59.
- hour_bcd  input  8  hours, BCD 00-23.
- day_bcd  input  8  day of week, BCD 01-07.
- date_bcd  input  8  day of month, BCD 01-31.
- month_bcd  input  8  month, BCD 01-12.
- year_bcd  input  8  year, BCD 00-99.
- i2c_read_en  input  1  I2C read request; a downstream read has priority and discards a concurrent write.
- addr  output  4  register address for the current write.
- data_out  output  8  data for the current write.
- write_en  output  1  write request to the downstream register mux.
- busy  output  1  a refresh sequence is in progress.
- done  output  1  one-cycle pulse after the last field is accepted.
- overrun  output  1  sticky flag: update_pulse arrived while busy.
- bcd_err  output  1  sticky flag: invalid BCD field detected (see REQ-016).

Function
REQ-003 SHALL be an FSM with states IDLE and WRITE; all outputs SHALL be registered.
REQ-004 In IDLE, on an edge with update_pulse=1 or pending=1: SHALL capture all seven inputs into shadow registers, clear pending, set idx=0, and enter WRITE.
- In the same edge, SHALL drive addr=BASE_ADDR, data_out=shadow sec, write_en=1, busy=1.
REQ-005 In WRITE, a write SHALL count as accepted at an edge where write_en=1 and i2c_read_en=0.
REQ-006 On an edge with write_en=1 and i2c_read_en=1, the write SHALL count as not accepted.
- addr, data_out and idx SHALL hold, and write_en SHALL stay 1 (retry).
REQ-007 On acceptance with idx<6: SHALL increment idx, set addr=BASE_ADDR+idx+1, and load the next shadow field.
- Field order: sec, min, hour, day, date, month, year.
REQ-008 On acceptance with idx=6: SHALL return to IDLE and, in the same edge, set write_en=0, busy=0, done=1.
REQ-009 done SHALL be high for exactly one cycle.
REQ-010 Unstalled latency: seven consecutive write_en cycles starting at the capture edge; done in the 8th cycle.
REQ-011 Shadow registers SHALL NOT change during WRITE, so the seven fields are a coherent snapshot.
REQ-012 update_pulse while busy SHALL set pending=1 and overrun=1.
- Multiple such pulses SHALL collapse into one pending refresh.
- The pending refresh SHALL start at the first IDLE edge (one cycle after done).
REQ-013 An update_pulse arriving on the same edge as the final acceptance SHALL set pending; it SHALL NOT be lost.
REQ-014 addr arithmetic SHALL be 4-bit and wrap modulo 16.
REQ-015 write_en SHALL be 0 whenever in IDLE.

Reset
REQ-017 rst_n=0 SHALL immediately force the following, including mid-sequence:
- state=IDLE, idx=0, pending=0.
- Shadow registers, addr and data_out to 0.
- write_en, busy, done, overrun and bcd_err to 0.
REQ-018 After rst_n deasserts, SHALL take no action until an update_pulse arrives.

Configuration
REQ-016 Macro BCD_CHECK_EN:
- When defined, SHALL check every captured field at capture time.
- Any nibble greater than 9 SHALL replace that field's shadow value with 8'h00 and set bcd_err=1 (sticky until reset).
- When undefined, fields SHALL pass unchanged and bcd_err SHALL be tied to 0.

Verification
REQ-019 Reset, then pulse with sec=0x45, min=0x30, hour=0x12, day=0x03, date=0x28, month=0x02, year=0x24; i2c_read_en=0.
- Required response: addr 0..6 with those data on seven consecutive cycles; done in cycle 8.
REQ-020 As REQ-019, with i2c_read_en=1 for 2 cycles while addr=2.
- Required response: addr=2, data 0x12 held 3 cycles; sequence completes in 9 write cycles; no field skipped.
REQ-021 Pulse, change sec input to 0x46 mid-sequence, then pulse again at idx=3.
- Required response: first sequence writes 0x45; overrun=1; second sequence starts one cycle after done and writes 0x46.
REQ-022 Assert rst_n=0 at idx=4.
- Required response: write_en=0, busy=0, addr=0 immediately; no done pulse.
REQ-023 With BCD_CHECK_EN defined, min=0x5A.
- Required response: addr 1 written with 0x00; bcd_err=1. Without the macro: 0x5A written; bcd_err=0.
REQ-024 BASE_ADDR=4'hC, unstalled sequence.
- Required response: addresses C, D, E, F, 0, 1, 2.
